// File: rtl/qmax_update_ctrl.sv
// ============================================================================
// Module      : qmax_update_ctrl
// Description : Shares the qmax BRAM between read-compare-write updates and
//               read-only queries; forwards writes and sequences table clears.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module qmax_update_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_upd_valid,
    output logic                  o_upd_ready,
    input  logic [ADDR_WIDTH-1:0] i_upd_addr,
    input  logic [DATA_WIDTH-1:0] i_upd_q,
    output logic                  o_upd_done,
    output logic                  o_upd_changed,
    output logic [DATA_WIDTH-1:0] o_upd_qmax,
    input  logic                  i_qry_valid,
    output logic                  o_qry_ready,
    input  logic [ADDR_WIDTH-1:0] i_qry_addr,
    output logic                  o_qry_valid,
    output logic [DATA_WIDTH-1:0] o_qry_data,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_mem_addr_r,
    output logic [ADDR_WIDTH-1:0] o_mem_addr_w,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam logic [1:0]            c_st_run    = 2'd0;
    localparam logic [1:0]            c_st_drain  = 2'd1;
    localparam logic [1:0]            c_st_clear  = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

    logic [1:0]            r_state;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_rr;        // 0: update wins the next contention

    logic                  r_s1_valid;
    logic                  r_s1_is_upd;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DATA_WIDTH-1:0] r_s1_q;

    logic                  r_fwd_valid;
    logic [ADDR_WIDTH-1:0] r_fwd_addr;
    logic [DATA_WIDTH-1:0] r_fwd_val;

    logic                  r_upd_done;
    logic                  r_upd_changed;
    logic [DATA_WIDTH-1:0] r_upd_qmax;
    logic                  r_qry_valid;
    logic [DATA_WIDTH-1:0] r_qry_data;

    logic                  w_accept_ok;
    logic                  w_upd_fire;
    logic                  w_qry_fire;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_clearing;
    logic                  w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_cur;
    logic                  w_s1_upd;
    logic                  w_s1_qry;
    logic                  w_do_write;

    assign w_accept_ok = (r_state == c_st_run) && !i_clear;
    assign o_upd_ready = w_accept_ok && (!i_qry_valid || !r_rr);
    assign o_qry_ready = w_accept_ok && (!i_upd_valid ||  r_rr);
    assign w_upd_fire  = i_upd_valid && o_upd_ready;
    assign w_qry_fire  = i_qry_valid && o_qry_ready;
    assign w_rd_addr   = w_qry_fire ? i_qry_addr : i_upd_addr;

    // A read issued alongside a same-address write returns stale data, so
    // the value written one cycle ago takes precedence over the BRAM output.
    assign w_fwd_hit  = r_fwd_valid && (r_fwd_addr == r_s1_addr);
    assign w_cur      = w_fwd_hit ? r_fwd_val : i_mem_rdata;
    assign w_s1_upd   = r_s1_valid &&  r_s1_is_upd;
    assign w_s1_qry   = r_s1_valid && !r_s1_is_upd;
    assign w_do_write = w_s1_upd && (r_s1_q > w_cur);
    assign w_clearing = (r_state == c_st_clear);

    assign o_mem_addr_r = w_rd_addr;
    assign o_mem_we     = w_clearing || w_do_write;
    assign o_mem_addr_w = w_clearing ? r_clr_addr : r_s1_addr;
    assign o_mem_wdata  = w_clearing ? '0 : r_s1_q;

    assign o_upd_done    = r_upd_done;
    assign o_upd_changed = r_upd_changed;
    assign o_upd_qmax    = r_upd_qmax;
    assign o_qry_valid   = r_qry_valid;
    assign o_qry_data    = r_qry_data;
    assign o_busy        = r_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= c_st_run;
            r_busy     <= 1'b0;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (i_clear) r_state <= c_st_drain;
                end
                c_st_drain: begin
                    r_state    <= c_st_clear;
                    r_busy     <= 1'b1;
                    r_clr_addr <= '0;
                end
                c_st_clear: begin
                    if (r_clr_addr == c_last_addr) begin
                        r_state <= c_st_run;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_run;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr          <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_is_upd   <= 1'b0;
            r_s1_addr     <= '0;
            r_s1_q        <= '0;
            r_fwd_valid   <= 1'b0;
            r_fwd_addr    <= '0;
            r_fwd_val     <= '0;
            r_upd_done    <= 1'b0;
            r_upd_changed <= 1'b0;
            r_upd_qmax    <= '0;
            r_qry_valid   <= 1'b0;
            r_qry_data    <= '0;
        end else begin
            if (i_upd_valid && i_qry_valid && w_accept_ok) r_rr <= ~r_rr;

            r_s1_valid  <= w_upd_fire || w_qry_fire;
            r_s1_is_upd <= w_upd_fire;
            r_s1_addr   <= w_rd_addr;
            r_s1_q      <= i_upd_q;

            r_fwd_valid <= w_do_write && !w_clearing;
            r_fwd_addr  <= r_s1_addr;
            r_fwd_val   <= r_s1_q;

            r_upd_done  <= w_s1_upd;
            r_qry_valid <= w_s1_qry;
            if (w_s1_upd) begin
                r_upd_changed <= w_do_write;
                r_upd_qmax    <= w_do_write ? r_s1_q : w_cur;
            end
            if (w_s1_qry) r_qry_data <= w_cur;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_qmax_update_ctrl.sv
// ============================================================================
// Module      : tb_qmax_update_ctrl
// Description : Scoreboard bench for qmax_update_ctrl with a read-first BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_qmax_update_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic          r_clk = 1'b0;
    logic          r_rst_n = 1'b0;
    logic          r_upd_valid = 1'b0;
    logic [AW-1:0] r_upd_addr = '0;
    logic [DW-1:0] r_upd_q = '0;
    logic          r_qry_valid = 1'b0;
    logic [AW-1:0] r_qry_addr = '0;
    logic          r_clear = 1'b0;
    logic [DW-1:0] r_mem_rdata = '0;

    logic          w_upd_ready, w_upd_done, w_upd_changed;
    logic [DW-1:0] w_upd_qmax;
    logic          w_qry_ready, w_qry_valid;
    logic [DW-1:0] w_qry_data;
    logic          w_busy, w_mem_we;
    logic [AW-1:0] w_mem_addr_r, w_mem_addr_w;
    logic [DW-1:0] w_mem_wdata;

    qmax_update_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
        .i_clk(r_clk), .i_rst_n(r_rst_n),
        .i_upd_valid(r_upd_valid), .o_upd_ready(w_upd_ready),
        .i_upd_addr(r_upd_addr), .i_upd_q(r_upd_q),
        .o_upd_done(w_upd_done), .o_upd_changed(w_upd_changed), .o_upd_qmax(w_upd_qmax),
        .i_qry_valid(r_qry_valid), .o_qry_ready(w_qry_ready), .i_qry_addr(r_qry_addr),
        .o_qry_valid(w_qry_valid), .o_qry_data(w_qry_data),
        .i_clear(r_clear), .o_busy(w_busy),
        .o_mem_addr_r(w_mem_addr_r), .o_mem_addr_w(w_mem_addr_w),
        .o_mem_we(w_mem_we), .o_mem_wdata(w_mem_wdata), .i_mem_rdata(r_mem_rdata)
    );

    always #5 r_clk = ~r_clk;

    // Read-first BRAM with one cycle of read latency.
    logic [DW-1:0] r_mem [DEPTH];
    always @(posedge r_clk) begin
        r_mem_rdata <= r_mem[w_mem_addr_r];
        if (w_mem_we) r_mem[w_mem_addr_w] <= w_mem_wdata;
    end

    int r_cyc = 0;
    always @(posedge r_clk) r_cyc <= r_cyc + 1;

    typedef struct { int cyc; logic ch; logic [DW-1:0] val; } exp_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    exp_t upd_q[$];
    exp_t qry_q[$];
    wr_t  wr_q[$];
    exp_t r_e;
    wr_t  r_w;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, r_cyc);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got output %0d required no output (cycle %0d)", name, act, r_cyc);
    endtask

    logic r_prev_busy = 1'b0;
    int   clr_cycles = 0;
    int   clr_bad = 0;
    int   clr_idx = 0;

    always @(negedge r_clk) begin
        if (w_upd_done) begin
            if (upd_q.size() == 0) fail_unexpected("upd_unexpected", 32'(w_upd_qmax));
            else begin
                r_e = upd_q.pop_front();
                check("upd_latency", r_cyc, r_e.cyc);
                check("upd_changed", 32'(w_upd_changed), 32'(r_e.ch));
                check("upd_qmax", 32'(w_upd_qmax), 32'(r_e.val));
            end
        end
        if (w_qry_valid) begin
            if (qry_q.size() == 0) fail_unexpected("qry_unexpected", 32'(w_qry_data));
            else begin
                r_e = qry_q.pop_front();
                check("qry_latency", r_cyc, r_e.cyc);
                check("qry_data", 32'(w_qry_data), 32'(r_e.val));
            end
        end
        if (w_mem_we && !w_busy) begin
            if (wr_q.size() == 0) fail_unexpected("mem_write_unexpected", 32'(w_mem_addr_w));
            else begin
                r_w = wr_q.pop_front();
                check("wr_cycle", r_cyc, r_w.cyc);
                check("wr_addr", 32'(w_mem_addr_w), 32'(r_w.addr));
                check("wr_data", 32'(w_mem_wdata), 32'(r_w.data));
            end
        end
        if (w_busy) begin
            if (!r_prev_busy) begin
                clr_cycles = 0;
                clr_bad    = 0;
                clr_idx    = 0;
            end
            clr_cycles++;
            if (!w_mem_we || w_mem_wdata != '0 || int'(w_mem_addr_w) != clr_idx) clr_bad++;
            clr_idx++;
        end
        r_prev_busy = w_busy;
    end

    // One cycle of stimulus; expectations are pushed only for granted requests.
    task automatic drive(input logic uv, input logic [AW-1:0] ua, input logic [DW-1:0] uq,
                         input logic qv, input logic [AW-1:0] qa,
                         input logic eug, input logic eqg,
                         input logic ech, input logic [DW-1:0] eqm, input logic [DW-1:0] eqd);
        logic ug, qg;
        @(negedge r_clk);
        r_upd_valid = uv; r_upd_addr = ua; r_upd_q = uq;
        r_qry_valid = qv; r_qry_addr = qa;
        #1;
        ug = uv && w_upd_ready;
        qg = qv && w_qry_ready;
        check("upd_grant", 32'(ug), 32'(eug));
        check("qry_grant", 32'(qg), 32'(eqg));
        if (ug) begin
            upd_q.push_back('{r_cyc + 2, ech, eqm});
            if (ech) wr_q.push_back('{r_cyc + 1, ua, uq});
        end
        if (qg) qry_q.push_back('{r_cyc + 2, 1'b0, eqd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge r_clk);
            r_upd_valid = 1'b0;
            r_qry_valid = 1'b0;
        end
    endtask

    task automatic start_clear(input logic traffic, output int t);
        @(negedge r_clk);
        r_clear = 1'b1;
        r_upd_valid = traffic; r_upd_addr = 8'd40; r_upd_q = 8'd1;
        r_qry_valid = traffic; r_qry_addr = 8'd41;
        #1;
        check("clear_upd_ready", 32'(w_upd_ready), 0);
        check("clear_qry_ready", 32'(w_qry_ready), 0);
        t = r_cyc;
        @(negedge r_clk);
        r_clear = 1'b0;
        r_upd_valid = 1'b0;
        r_qry_valid = 1'b0;
    endtask

    task automatic finish_clear(input int t);
        int rdy_cyc;
        rdy_cyc = -1;
        for (int i = 0; i < DEPTH + 20 && rdy_cyc < 0; i++) begin
            #1;
            if (w_upd_ready && w_qry_ready) rdy_cyc = r_cyc;
            else @(negedge r_clk);
        end
        check("clear_ready_cycle", 32'(rdy_cyc), 32'(t + 2 + DEPTH));
        check("clear_busy_cycles", 32'(clr_cycles), 32'(DEPTH));
        check("clear_write_errors", 32'(clr_bad), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", r_cyc);
        $fatal(1);
    end

    initial begin
        int t;
        logic found;
        repeat (3) @(negedge r_clk);
        check("rst_upd_done", 32'(w_upd_done), 0);
        check("rst_upd_changed", 32'(w_upd_changed), 0);
        check("rst_upd_qmax", 32'(w_upd_qmax), 0);
        check("rst_qry_valid", 32'(w_qry_valid), 0);
        check("rst_qry_data", 32'(w_qry_data), 0);
        check("rst_busy", 32'(w_busy), 0);
        check("rst_mem_we", 32'(w_mem_we), 0);
        r_rst_n = 1'b1;

        start_clear(1'b0, t);
        finish_clear(t);

        // Read-compare-write through the BRAM path.
        drive(1, 8'd5, 8'd10, 0, 8'd0, 1, 0, 1, 8'd10, 8'd0); idle(2);
        drive(1, 8'd5, 8'd20, 0, 8'd0, 1, 0, 1, 8'd20, 8'd0); idle(2);
        drive(1, 8'd5, 8'd15, 0, 8'd0, 1, 0, 0, 8'd20, 8'd0); idle(1);

        // Back-to-back same-address updates rely on forwarding.
        drive(1, 8'd7, 8'd3, 0, 8'd0, 1, 0, 1, 8'd3, 8'd0);
        drive(1, 8'd7, 8'd9, 0, 8'd0, 1, 0, 1, 8'd9, 8'd0);
        drive(1, 8'd7, 8'd4, 0, 8'd0, 1, 0, 0, 8'd9, 8'd0);
        drive(0, 8'd0, 8'd0, 1, 8'd7, 0, 1, 0, 8'd0, 8'd9);
        drive(1, 8'd8, 8'd6, 0, 8'd0, 1, 0, 1, 8'd6, 8'd0);
        drive(0, 8'd0, 8'd0, 1, 8'd8, 0, 1, 0, 8'd0, 8'd6);
        idle(2);

        // Contention alternates grants, starting with update.
        drive(1, 8'd20, 8'd1, 1, 8'd5, 1, 0, 1, 8'd1, 8'd0);
        drive(1, 8'd21, 8'd0, 1, 8'd5, 0, 1, 0, 8'd0, 8'd20);
        drive(1, 8'd21, 8'd0, 1, 8'd7, 1, 0, 0, 8'd0, 8'd0);
        drive(1, 8'd22, 8'd2, 1, 8'd7, 0, 1, 0, 8'd0, 8'd9);
        drive(1, 8'd22, 8'd2, 0, 8'd0, 1, 0, 1, 8'd2, 8'd0);
        idle(2);

        // Equal value never writes; all-ones over zero does.
        drive(1, 8'd5, 8'd20, 0, 8'd0, 1, 0, 0, 8'd20, 8'd0); idle(1);
        drive(1, 8'd9, 8'd255, 0, 8'd0, 1, 0, 1, 8'd255, 8'd0); idle(1);
        drive(0, 8'd0, 8'd0, 1, 8'd9, 0, 1, 0, 8'd0, 8'd255);

        // Clear with a request still in stage 1 and both requesters pending.
        drive(1, 8'd30, 8'd7, 0, 8'd0, 1, 0, 1, 8'd7, 8'd0);
        start_clear(1'b1, t);
        finish_clear(t);
        drive(0, 8'd0, 8'd0, 1, 8'd0, 0, 1, 0, 8'd0, 8'd0);
        drive(0, 8'd0, 8'd0, 1, 8'd128, 0, 1, 0, 8'd0, 8'd0);
        drive(0, 8'd0, 8'd0, 1, 8'd255, 0, 1, 0, 8'd0, 8'd0);
        drive(0, 8'd0, 8'd0, 1, 8'd30, 0, 1, 0, 8'd0, 8'd0);
        drive(0, 8'd0, 8'd0, 1, 8'd9, 0, 1, 0, 8'd0, 8'd0);
        idle(3);

        // Asynchronous reset in the middle of a clear.
        start_clear(1'b0, t);
        found = 1'b0;
        for (int i = 0; i < DEPTH + 20 && !found; i++) begin
            @(negedge r_clk);
            if (w_busy && w_mem_addr_w == 8'd50) found = 1'b1;
        end
        check("mid_clear_addr", 32'(w_mem_addr_w), 50);
        #1 r_rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(w_busy), 0);
        check("midrst_mem_we", 32'(w_mem_we), 0);
        check("midrst_outputs", {28'd0, w_upd_done, w_upd_changed, w_qry_valid, 1'b0}, 0);
        check("midrst_data", {16'd0, w_upd_qmax, w_qry_data}, 0);
        @(negedge r_clk);
        r_rst_n = 1'b1;
        r_upd_valid = 1'b1;
        r_qry_valid = 1'b0;
        #1;
        check("midrst_upd_ready", 32'(w_upd_ready), 1);
        check("midrst_busy_after", 32'(w_busy), 0);
        r_upd_valid = 1'b0;
        r_qry_valid = 1'b1;
        #1;
        check("midrst_qry_ready", 32'(w_qry_ready), 1);
        r_qry_valid = 1'b0;

        start_clear(1'b0, t);
        finish_clear(t);
        drive(0, 8'd0, 8'd0, 1, 8'd5, 0, 1, 0, 8'd0, 8'd0);
        drive(1, 8'd5, 8'd1, 0, 8'd0, 1, 0, 1, 8'd1, 8'd0);
        idle(4);

        check("pending_upd", 32'(upd_q.size()), 0);
        check("pending_qry", 32'(qry_q.size()), 0);
        check("pending_wr", 32'(wr_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
